// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions: mode codes understood by the shared ALU and its clients.
package alu_mul_seq_pkg;

  localparam int unsigned AluModeW = 3;

  localparam logic [AluModeW-1:0] ALU_ADD  = 3'd0;
  localparam logic [AluModeW-1:0] ALU_SUB  = 3'd1;
  localparam logic [AluModeW-1:0] ALU_AND  = 3'd2;
  localparam logic [AluModeW-1:0] ALU_OR   = 3'd3;
  localparam logic [AluModeW-1:0] ALU_XOR  = 3'd4;
  localparam logic [AluModeW-1:0] ALU_INC  = 3'd5;
  localparam logic [AluModeW-1:0] ALU_DEC  = 3'd6;
  localparam logic [AluModeW-1:0] ALU_PASS = 3'd7;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Shared ALU with a registered result and zero flag, valid one cycle after an enabled edge.
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [AluModeW-1:0] i_mode,
  input  logic [N-1:0]        i_a,
  input  logic [N-1:0]        i_b,
  output logic [N-1:0]        o_result,
  output logic                o_zero
);

  logic [N-1:0] r_result;
  logic         r_zero;
  logic [N-1:0] w_result;

  // Combinational operation select.
  always_comb begin
    w_result = '0;
    case (i_mode)
      ALU_ADD:  w_result = i_a + i_b;
      ALU_SUB:  w_result = i_a - i_b;
      ALU_AND:  w_result = i_a & i_b;
      ALU_OR:   w_result = i_a | i_b;
      ALU_XOR:  w_result = i_a ^ i_b;
      ALU_INC:  w_result = i_a + 1'b1;
      ALU_DEC:  w_result = i_a - 1'b1;
      ALU_PASS: w_result = i_a;
      default:  w_result = '0;
    endcase
  end

  // Result and zero flag register; holds while not enabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (i_enable) begin
      r_result <= w_result;
      r_zero   <= (w_result == '0);
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-free multiplier: repeated addition driven through an external shared ALU.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N-1:0]        op_a,
  input  logic [N-1:0]        op_b,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        product,
  output logic                overflow,
  output logic                alu_enable,
  output logic [AluModeW-1:0] alu_mode,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  input  logic [N-1:0]        alu_out,
  input  logic                alu_zero
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAddIssue = 3'd1,
    StAddWb    = 3'd2,
    StDecIssue = 3'd3,
    StDecWb    = 3'd4,
    StDone     = 3'd5
  } state_e;

  state_e       r_state, w_state_d;
  logic [N-1:0] r_mcand, r_count, r_acc, r_product;
  logic         r_ovf, r_overflow;
  logic         w_zero_op;

  assign w_zero_op = (op_a == '0) || (op_b == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state and ALU request decode; ALU inputs idle at ADD/0/0 outside issue states.
  always_comb begin
    w_state_d  = r_state;
    alu_enable = 1'b0;
    alu_mode   = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    case (r_state)
      StIdle: begin
        if (start) w_state_d = w_zero_op ? StDone : StAddIssue;
      end
      StAddIssue: begin
        alu_enable = 1'b1;
        alu_mode   = ALU_ADD;
        alu_a      = r_acc;
        alu_b      = r_mcand;
        w_state_d  = StAddWb;
      end
      StAddWb: w_state_d = StDecIssue;
      StDecIssue: begin
        alu_enable = 1'b1;
        alu_mode   = ALU_DEC;
        alu_a      = r_count;
        alu_b      = '0;
        w_state_d  = StDecWb;
      end
      StDecWb: w_state_d = alu_zero ? StDone : StAddIssue;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, accumulate/count write-back, result publish.
  // product/overflow are loaded on the edge entering DONE so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand    <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand <= op_a;
            r_count <= op_b;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            if (w_zero_op) begin
              r_product  <= '0;
              r_overflow <= 1'b0;
            end
          end
        end
        StAddWb: begin
          r_acc <= alu_out;
          // Unsigned wrap of acc + mcand shows up as a smaller sum.
          if (alu_out < r_acc) r_ovf <= 1'b1;
        end
        StDecWb: begin
          r_count <= alu_out;
          if (alu_zero) begin
            r_product  <= r_acc;
            r_overflow <= r_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StDone);
  assign product  = r_product;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq paired with the shared ALU.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  localparam int unsigned N = 8;

  logic                clk = 1'b0;
  logic                reset, start;
  logic [N-1:0]        op_a, op_b;
  logic                busy, done, overflow;
  logic [N-1:0]        product;
  logic                alu_enable, alu_zero;
  logic [AluModeW-1:0] alu_mode;
  logic [N-1:0]        alu_a, alu_b, alu_out;

  always #5 clk = ~clk;

  alu_mul_seq #(.N(N)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .overflow   (overflow),
    .alu_enable (alu_enable),
    .alu_mode   (alu_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero)
  );

  alu_mul_seq_alu #(.N(N)) u_alu (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (alu_enable),
    .i_mode   (alu_mode),
    .i_a      (alu_a),
    .i_b      (alu_b),
    .o_result (alu_out),
    .o_zero   (alu_zero)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] prod;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance cycle by cycle until done; lat counts edges from the cycle start was presented.
  task automatic wait_done(input int budget, input bit hold, input bit chg,
                           input logic [N-1:0] na, input logic [N-1:0] nb,
                           output int lat, output int en, output bit seen);
    lat  = 0;
    en   = 0;
    seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      if (chg) begin
        op_a = na;
        op_b = nb;
      end
      @(negedge clk);
      if (alu_enable) en++;
      if (!alu_enable && (alu_mode != ALU_ADD || alu_a != '0 || alu_b != '0)) viol++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  // Pop the expected record and compare against what was observed.
  task automatic score(input string tag, input bit seen, input int lat, input int en);
    vec_t e;
    int   en_exp;
    e = sb.pop_front();
    en_exp = (e.a == '0 || e.b == '0) ? 0 : 2 * int'(e.b);
    if (!seen) begin
      chk({tag, " done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, lat, e.lat);
      chk({tag, " product"}, product, e.prod);
      chk({tag, " overflow"}, overflow, e.ovf);
      chk({tag, " alu_en_cycles"}, en, en_exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int lat, en;
    bit seen;
    @(negedge clk);
    op_a  = v.a;
    op_b  = v.b;
    start = 1'b1;
    sb.push_back(v);
    wait_done(4 * 256 + 20, 1'b0, 1'b1, N'($urandom), N'($urandom), lat, en, seen);
    score(tag, seen, lat, en);
    // Pulse must end after one cycle and results must hold.
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " product_hold"}, product, v.prod);
    chk({tag, " overflow_hold"}, overflow, v.ovf);
  endtask

  initial begin
    int  lat, en, ndone;
    bit  seen;
    vec_t v;

    vecs[0] = '{a: 8'd3,   b: 8'd4,   prod: 8'd12,  ovf: 1'b0, lat: 17};
    vecs[1] = '{a: 8'd7,   b: 8'd0,   prod: 8'd0,   ovf: 1'b0, lat: 1};
    vecs[2] = '{a: 8'd255, b: 8'd2,   prod: 8'd254, ovf: 1'b1, lat: 9};
    vecs[3] = '{a: 8'd0,   b: 8'd9,   prod: 8'd0,   ovf: 1'b0, lat: 1};
    vecs[4] = '{a: 8'd5,   b: 8'd1,   prod: 8'd5,   ovf: 1'b0, lat: 5};
    vecs[5] = '{a: 8'd16,  b: 8'd16,  prod: 8'd0,   ovf: 1'b1, lat: 65};
    vecs[6] = '{a: 8'd15,  b: 8'd17,  prod: 8'd255, ovf: 1'b0, lat: 69};
    vecs[7] = '{a: 8'd1,   b: 8'd255, prod: 8'd255, ovf: 1'b0, lat: 1021};
    vecs[8] = '{a: 8'd200, b: 8'd3,   prod: 8'd88,  ovf: 1'b1, lat: 13};
    vecs[9] = '{a: 8'd128, b: 8'd2,   prod: 8'd0,   ovf: 1'b1, lat: 9};

    // Reset wins over a pending start.
    reset = 1'b1;
    start = 1'b1;
    op_a  = 8'd3;
    op_b  = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst product", product, 8'd0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst alu_enable", alu_enable, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // start held high; operands change while busy and must not disturb the op.
    @(negedge clk);
    op_a  = 8'd5;
    op_b  = 8'd3;
    start = 1'b1;
    sb.push_back('{a: 8'd5, b: 8'd3, prod: 8'd15, ovf: 1'b0, lat: 13});
    wait_done(200, 1'b1, 1'b1, 8'd9, 8'd9, lat, en, seen);
    score("held", seen, lat, en);
    @(negedge clk);
    chk("held single_done", done, 1'b0);
    chk("held idle", busy, 1'b0);
    sb.push_back('{a: 8'd9, b: 8'd9, prod: 8'd81, ovf: 1'b0, lat: 37});
    wait_done(200, 1'b0, 1'b0, 8'd0, 8'd0, lat, en, seen);
    score("held_next", seen, lat, en);

    // Reset in ADD_WB abandons 6*5 with no done pulse.
    @(negedge clk);
    op_a  = 8'd6;
    op_b  = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst busy_before", busy, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst product", product, 8'd0);
    chk("midrst overflow", overflow, 1'b0);
    chk("midrst alu_enable", alu_enable, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst quiet", ndone, 0);
    v = '{a: 8'd5, b: 8'd1, prod: 8'd5, ovf: 1'b0, lat: 5};
    run_op("after_rst", v);

    chk("alu_idle_violations", viol, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
